// File: rtl/snd_dma_pkg.sv
// Shared types and helpers for the multi-channel sound DMA slice.
package snd_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } chan_state_t;

  localparam int MAX_NCH = 8;

  // One-hot pick of the first set request at or after ptr, wrapping over MAX_NCH.
  // Positions above the real channel count carry no request, so wrapping over
  // MAX_NCH behaves the same as wrapping over the real channel count.
  function automatic logic [MAX_NCH-1:0] rr_pick(input logic [MAX_NCH-1:0] req,
                                                 input logic [2:0]         ptr);
    logic [MAX_NCH-1:0] gnt;
    logic               found;
    logic [2:0]         idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NCH; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/snd_dma_if.sv
// Bus-slot handshake and per-channel control bundle between the sound DMA and its host.
interface snd_dma_if #(
  parameter int NCH = 2,
  parameter int AW  = 21
) ();

  logic              slot_en;
  logic [NCH-1:0]    sndon;
  logic [NCH-1:0]    sfrep;
  logic [NCH-1:0]    sreq;
  logic [NCH*AW-1:0] fstart;
  logic [NCH*AW-1:0] fend;
  logic [AW-1:0]     snd_addr;
  logic              sadsel;
  logic              sload_n;
  logic [NCH-1:0]    sgnt;
  logic [NCH-1:0]    sframe;
  logic [NCH-1:0]    sint;
  logic [NCH-1:0]    stoff;

  modport master (
    input  slot_en, sndon, sfrep, sreq, fstart, fend,
    output snd_addr, sadsel, sload_n, sgnt, sframe, sint, stoff
  );

  modport slave (
    output slot_en, sndon, sfrep, sreq, fstart, fend,
    input  snd_addr, sadsel, sload_n, sgnt, sframe, sint, stoff
  );

endinterface

// File: rtl/snd_dma_chan.sv
// One sound DMA channel: frame FSM, end-address shadow, fetch address counter and
// frame-end / self-stop pulses.
module snd_dma_chan
  import snd_dma_pkg::*;
#(
  parameter int AW = 21
) (
  input  logic          clk32,
  input  logic          porb,
  input  logic          resb,
  input  logic          slot_en,
  input  logic          sndon,
  input  logic          sfrep,
  input  logic          grant,
  input  logic [AW-1:0] fstart,
  input  logic [AW-1:0] fend,
  output logic [AW-1:0] cnt,
  output logic          run,
  output logic          sframe,
  output logic          sint,
  output logic          stoff
);

  chan_state_t   state_r;
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] end_r;
  logic          sframe_r;
  logic          sint_r;
  logic          stoff_r;

  // Channel FSM; sndon low aborts from any state on any cycle.
  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      end_r    <= '0;
      sframe_r <= 1'b0;
      sint_r   <= 1'b0;
      stoff_r  <= 1'b0;
    end else if (!resb) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      end_r    <= '0;
      sframe_r <= 1'b0;
      sint_r   <= 1'b0;
      stoff_r  <= 1'b0;
    end else if (!sndon) begin
      state_r  <= IDLE;
      sframe_r <= 1'b0;
      sint_r   <= 1'b0;
      stoff_r  <= 1'b0;
    end else begin
      sint_r  <= 1'b0;
      stoff_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (slot_en) begin
            state_r  <= RUN;
            cnt_r    <= fstart;
            end_r    <= fend;
            sframe_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (grant) begin
            // Plain increment wraps through 0 when the end lies below the start.
            if (cnt_r != end_r) begin
              cnt_r <= cnt_r + AW'(1);
            end else if (sfrep) begin
              cnt_r  <= fstart;
              end_r  <= fend;
              sint_r <= 1'b1;
            end else begin
              state_r  <= STOP;
              sframe_r <= 1'b0;
              sint_r   <= 1'b1;
              stoff_r  <= 1'b1;
            end
          end else begin
            state_r <= RUN;
          end
        end
        STOP:    state_r <= STOP;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign cnt    = cnt_r;
  assign run    = (state_r == RUN);
  assign sframe = sframe_r;
  assign sint   = sint_r;
  assign stoff  = stoff_r;

endmodule

// File: rtl/snd_dma_multi.sv
// Multi-channel sound DMA: NCH channels sharing one bus slot per slot_en through a
// round-robin or fixed-priority arbiter, with registered grant outputs.
module snd_dma_multi
  import snd_dma_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 21,
  parameter int RR  = 1
) (
  input  logic      clk32,
  input  logic      porb,
  input  logic      resb,
  snd_dma_if.master bus
);

  logic [AW-1:0]      cnt_s [NCH];
  logic [NCH-1:0]     run_s;
  logic [NCH-1:0]     sframe_s;
  logic [NCH-1:0]     sint_s;
  logic [NCH-1:0]     stoff_s;
  logic [NCH-1:0]     gnt_s;
  logic [MAX_NCH-1:0] req8_s;
  logic [MAX_NCH-1:0] pick_s;
  logic [2:0]         gidx_s;
  logic [AW-1:0]      gaddr_s;
  logic [2:0]         ptr_r;
  logic               sadsel_r;
  logic               sload_n_r;
  logic [NCH-1:0]     sgnt_r;
  logic [AW-1:0]      snd_addr_r;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    snd_dma_chan #(.AW(AW)) u_chan (
      .clk32  (clk32),
      .porb   (porb),
      .resb   (resb),
      .slot_en(bus.slot_en),
      .sndon  (bus.sndon[g]),
      .sfrep  (bus.sfrep[g]),
      .grant  (gnt_s[g]),
      .fstart (bus.fstart[g*AW +: AW]),
      .fend   (bus.fend[g*AW +: AW]),
      .cnt    (cnt_s[g]),
      .run    (run_s[g]),
      .sframe (sframe_s[g]),
      .sint   (sint_s[g]),
      .stoff  (stoff_s[g])
    );
  end

  // Eligibility masks out a channel whose sndon is falling this cycle.
  always_comb begin
    req8_s          = '0;
    req8_s[NCH-1:0] = run_s & bus.sreq & bus.sndon;
    pick_s          = rr_pick(req8_s, (RR != 0) ? ptr_r : 3'd0);
    gnt_s           = bus.slot_en ? pick_s[NCH-1:0] : '0;
  end

  // Granted channel index and its fetch address.
  always_comb begin
    gidx_s  = 3'd0;
    gaddr_s = '0;
    for (int i = 0; i < MAX_NCH; i++) begin
      gidx_s = pick_s[i] ? 3'(i) : gidx_s;
    end
    for (int i = 0; i < NCH; i++) begin
      gaddr_s = gnt_s[i] ? cnt_s[i] : gaddr_s;
    end
  end

  // Grant output registers and round-robin pointer (next channel to search first).
  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      sadsel_r   <= 1'b0;
      sload_n_r  <= 1'b1;
      sgnt_r     <= '0;
      snd_addr_r <= '0;
      ptr_r      <= 3'd0;
    end else if (!resb) begin
      sadsel_r   <= 1'b0;
      sload_n_r  <= 1'b1;
      sgnt_r     <= '0;
      snd_addr_r <= '0;
      ptr_r      <= 3'd0;
    end else begin
      sadsel_r  <= |gnt_s;
      sload_n_r <= ~(|gnt_s);
      sgnt_r    <= gnt_s;
      if (|gnt_s) begin
        snd_addr_r <= gaddr_s;
        ptr_r      <= (gidx_s >= 3'(NCH - 1)) ? 3'd0 : gidx_s + 3'd1;
      end else begin
        snd_addr_r <= snd_addr_r;
        ptr_r      <= ptr_r;
      end
    end
  end

  assign bus.snd_addr = snd_addr_r;
  assign bus.sadsel   = sadsel_r;
  assign bus.sload_n  = sload_n_r;
  assign bus.sgnt     = sgnt_r;
  assign bus.sframe   = sframe_s;
  assign bus.sint     = sint_s;
  assign bus.stoff    = stoff_s;

endmodule
